// File: rtl/pipe_register_stage.sv
// One data-plus-valid stage of the pipe_register delay line.
// Holds its contents when load is low; data only loads when the upstream word is valid.
module pipe_register_stage #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Flush clears only the valid flag; stale data stays put.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_register.sv
// Stallable DEPTH-stage valid/ready delay line with bubble collapse, flush and occupancy count.
// Optional macro PIPE_REGISTER_STALL_CNT_EN adds a saturating 16-bit output-stall counter.
module pipe_register #(
  parameter int unsigned  WIDTH = 4,
  parameter int unsigned  DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
`ifdef PIPE_REGISTER_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data [DEPTH];
  logic             accept;

  // Move chain resolves from the output backward so a draining stage frees its predecessor.
  always_comb begin
    move = '0;
    load = '0;
    move[DEPTH-1] = valid[DEPTH-1] && out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      move[i] = valid[i] && (!valid[i+1] || move[i+1]);
    end
    load = ~valid | move;
  end

  assign in_ready  = load[0] && !clr && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
    logic             stg_in_valid;
    logic [WIDTH-1:0] stg_in_data;

    if (g == 0) begin : g_head
      assign stg_in_valid = accept;
      assign stg_in_data  = in_data;
    end else begin : g_body
      assign stg_in_valid = move[g-1];
      assign stg_in_data  = data[g-1];
    end

    pipe_register_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .load     (load[g]),
      .in_valid (stg_in_valid),
      .in_data  (stg_in_data),
      .valid    (valid[g]),
      .data     (data[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(accept) - CNT_W'(move[DEPTH-1]);
    end
  end

`ifdef PIPE_REGISTER_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_register.sv
// Scoreboarded bench for pipe_register: a DEPTH=2 instance carries the ordering checks,
// a DEPTH=3 instance shares the stimulus for the bubble-collapse case.
module tb_pipe_register;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_ready;

  logic             in_ready2, out_valid2;
  logic [WIDTH-1:0] out_data2;
  logic [1:0]       count2;
  logic             in_ready3, out_valid3;
  logic [WIDTH-1:0] out_data3;
  logic [1:0]       count3;
`ifdef PIPE_REGISTER_STALL_CNT_EN
  logic [15:0]      stall_cnt2, stall_cnt3;
`endif

  int n_vec;
  int n_err;
  logic [WIDTH-1:0] sb_q [$];

  pipe_register #(.WIDTH(WIDTH), .DEPTH(2)) u_dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_data   (in_data),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_data  (out_data2),
    .count     (count2)
`ifdef PIPE_REGISTER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt2)
`endif
  );

  pipe_register #(.WIDTH(WIDTH), .DEPTH(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .in_data   (in_data),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .out_data  (out_data3),
    .count     (count3)
`ifdef PIPE_REGISTER_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the DEPTH=2 instance: push on accept, pop on output transfer.
  always @(posedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid2 && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_out", 32'(out_data2), 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", 32'(out_data2), 32'(sb_q.pop_front()));
        end
      end
      if (clr) begin
        sb_q.delete();
      end else if (in_valid && in_ready2) begin
        sb_q.push_back(in_data);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hC;
    out_ready = 1'b0;

    // Reset held with input offered
    cyc(2);
    chk("rst_out_valid", 32'(out_valid2), 32'd0);
    chk("rst_out_data", 32'(out_data2), 32'd0);
    chk("rst_count", 32'(count2), 32'd0);
    chk("rst_in_ready", 32'(in_ready2), 32'd0);
    chk("rst_in_ready3", 32'(in_ready3), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    cyc(1);
    chk("idle_in_ready", 32'(in_ready2), 32'd1);

    // Streaming C,3,F with out_ready high
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = 4'hC;
    chk("st_in_ready", 32'(in_ready2), 32'd1);
    cyc(1);
    chk("st_lat_not_yet", 32'(out_valid2), 32'd0);
    chk("st_count1", 32'(count2), 32'd1);
    in_data = 4'h3;
    cyc(1);
    chk("st_out_valid_c", 32'(out_valid2), 32'd1);
    chk("st_out_data_c", 32'(out_data2), 32'hC);
    chk("st_count2a", 32'(count2), 32'd2);
    in_data = 4'hF;
    cyc(1);
    chk("st_out_data_3", 32'(out_data2), 32'h3);
    chk("st_count2b", 32'(count2), 32'd2);
    in_valid = 1'b0;
    cyc(1);
    chk("st_out_data_f", 32'(out_data2), 32'hF);
    chk("st_count1b", 32'(count2), 32'd1);
    cyc(2);
    chk("st_drained", 32'(count2), 32'd0);
    chk("st_empty_valid", 32'(out_valid2), 32'd0);

    // Backpressure: fill, refuse third word, then release
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'h1;
    cyc(1);
    in_data = 4'h2;
    cyc(1);
    chk("bp_count", 32'(count2), 32'd2);
    chk("bp_in_ready", 32'(in_ready2), 32'd0);
    chk("bp_out_data", 32'(out_data2), 32'h1);
    in_data = 4'h3;
    cyc(1);
    chk("bp_hold_data", 32'(out_data2), 32'h1);
    chk("bp_hold_count", 32'(count2), 32'd2);
    out_ready = 1'b1;
    #1;
    chk("bp_full_shift_ready", 32'(in_ready2), 32'd1);
    cyc(1);
    chk("bp_shift_count", 32'(count2), 32'd2);
    chk("bp_out_2", 32'(out_data2), 32'h2);
    in_valid = 1'b0;
    cyc(3);
    chk("bp_drained", 32'(count2), 32'd0);
    chk("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Bubble collapse on DEPTH=3: A, idle, B with out_ready low
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'hA;
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
    in_valid = 1'b1;
    in_data = 4'hB;
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
    chk("bub_count3", 32'(count3), 32'd2);
    chk("bub_out_valid3", 32'(out_valid3), 32'd1);
    chk("bub_out_data3", 32'(out_data3), 32'hA);
    chk("bub_in_ready3", 32'(in_ready3), 32'd1);
    chk("bub_full2", 32'(count2), 32'd2);

    // Flush with concurrent input offered
    clr = 1'b1;
    in_valid = 1'b1;
    in_data = 4'h5;
    #1;
    chk("clr_in_ready", 32'(in_ready2), 32'd0);
    cyc(1);
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_out_valid", 32'(out_valid2), 32'd0);
    chk("clr_count", 32'(count2), 32'd0);
    chk("clr_count3", 32'(count3), 32'd0);
    cyc(2);
    chk("clr_not_accepted", 32'(out_valid2), 32'd0);
    chk("clr_count_after", 32'(count2), 32'd0);

`ifdef PIPE_REGISTER_STALL_CNT_EN
    // Stall counter: word reaches output, then held for 5 cycles
    in_valid = 1'b1;
    in_data = 4'h7;
    cyc(1);
    in_valid = 1'b0;
    cyc(1);
    chk("stall_start", 32'(stall_cnt2), 32'd0);
    cyc(5);
    chk("stall_five", 32'(stall_cnt2), 32'd5);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("stall_clr", 32'(stall_cnt2), 32'd0);
`endif

    out_ready = 1'b1;
    cyc(4);
    chk("final_count", 32'(count2), 32'd0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
